// File: rtl/imem_boot_loader.sv
// Byte-stream program loader: LE header count, payload words into imem, optional checksum, then core release.
// Write appears 1 cycle after each 4th payload byte; ld_ready drops only in RUN/ERR, so there is no mid-load stall.
module imem_boot_loader #(
  parameter int          DATA_W      = 32,
  parameter int          ADDR_W      = 10,
  parameter logic [31:0] RESET_PC    = 32'h0,
  parameter bit          CHECKSUM_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_valid,
  input  logic [7:0]        ld_data,
  output logic              ld_ready,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_rst_n,
  output logic [31:0]       boot_pc,
  output logic              done,
  output logic              err
);

  localparam logic [31:0] MAX_WORDS = 32'(1) << ADDR_W;

  typedef enum logic [2:0] {HDR, DATA, CHK, RUN, ERR} state_t;

  state_t              state_q, state_d;
  logic [1:0]          bcnt_q, bcnt_d;
  logic [23:0]         shift_q, shift_d;
  logic [ADDR_W:0]     nwords_q, nwords_d;
  logic [ADDR_W:0]     widx_q, widx_d;
  logic [7:0]          csum_q, csum_d;
  logic                imem_we_d;
  logic [ADDR_W-1:0]   imem_addr_d;
  logic [DATA_W-1:0]   imem_wdata_d;
  logic                acc;
  logic [31:0]         full;

  assign boot_pc = RESET_PC;
  assign acc     = ld_valid && ld_ready;
  // The three earlier bytes sit in shift_q low-first, so this is the LE word.
  assign full    = {ld_data, shift_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= HDR;
      bcnt_q     <= '0;
      shift_q    <= '0;
      nwords_q   <= '0;
      widx_q     <= '0;
      csum_q     <= '0;
      ld_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_rst_n  <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_d;
      bcnt_q     <= bcnt_d;
      shift_q    <= shift_d;
      nwords_q   <= nwords_d;
      widx_q     <= widx_d;
      csum_q     <= csum_d;
      ld_ready   <= (state_d == HDR) || (state_d == DATA) || (state_d == CHK);
      imem_we    <= imem_we_d;
      imem_addr  <= imem_addr_d;
      imem_wdata <= imem_wdata_d;
      cpu_rst_n  <= (state_d == RUN);
      done       <= (state_d == RUN);
      err        <= (state_d == ERR);
    end
  end

  always_comb begin
    state_d      = state_q;
    bcnt_d       = bcnt_q;
    shift_d      = shift_q;
    nwords_d     = nwords_q;
    widx_d       = widx_q;
    csum_d       = csum_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr;
    imem_wdata_d = imem_wdata;

    if (reload) begin
      // Takes priority over any handshake this cycle; the byte is dropped.
      state_d  = HDR;
      bcnt_d   = '0;
      shift_d  = '0;
      nwords_d = '0;
      widx_d   = '0;
      csum_d   = '0;
    end else if (acc) begin
      shift_d = {ld_data, shift_q[23:8]};
      bcnt_d  = bcnt_q + 2'd1;
      case (state_q)
        HDR: begin
          if (bcnt_q == 2'd3) begin
            widx_d = '0;
            csum_d = '0;
            if (full == 32'd0) begin
              state_d = CHECKSUM_EN ? CHK : RUN;
            end else if (full > MAX_WORDS) begin
              state_d = ERR;
            end else begin
              nwords_d = full[ADDR_W:0];
              state_d  = DATA;
            end
          end
        end
        DATA: begin
          csum_d = csum_q + ld_data;
          if (bcnt_q == 2'd3) begin
            imem_we_d    = 1'b1;
            imem_addr_d  = widx_q[ADDR_W-1:0];
            imem_wdata_d = full[DATA_W-1:0];
            widx_d       = widx_q + 1'b1;
            if (widx_q + 1'b1 == nwords_q) begin
              state_d = CHECKSUM_EN ? CHK : RUN;
            end
          end
        end
        CHK: begin
          state_d = (ld_data == csum_q) ? RUN : ERR;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
